neuron_layer_sched: RTL and testbench

Sequencer that time-multiplexes one single-neuron MAC datapath across M neurons of a layer. Per neuron it clears the accumulator, steps the input/weight index 0..N-1 with load asserted, then captures the 16-bit datapath result into a result-register write port. It sits between the layer top and the shared datapath plus the input/weight selection logic, and replaces the per-neuron controller when the datapath is shared.

---
 rtl/neuron_pkg.sv | 23 ++
 rtl/neuron_layer_sched_step_counter.sv | 39 +++
 rtl/neuron_layer_sched.sv | 130 +++++++++++++
 tb/tb_neuron_layer_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron layer scheduler.
// FSM state encoding, default geometry, and the neuron-select width helper.
package neuron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        CAPT,
        DONE
    } state_t;

    localparam int N_DEF  = 10;
    localparam int M_DEF  = 4;
    localparam int IW_DEF = 16;
    localparam int OW_DEF = 16;

    // A single neuron still needs a 1-bit select bus.
    function automatic int nsel_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/neuron_layer_sched_step_counter.sv
// MAC step counter: drives the input/weight index and flags the last step (count == N-1).
module step_counter #(
    parameter int IW = 16,
    parameter int N  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] count,
    output logic          term
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] count_q;
    logic [IW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == LAST);

endmodule

// File: rtl/neuron_layer_sched.sv
// Shares one MAC datapath across M neurons: clear, N accumulate steps, capture, per neuron.
// Optional abort input is enabled by defining SCHED_ABORT_EN.
module neuron_layer_sched
    import neuron_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int IW = IW_DEF,
    parameter int OW = OW_DEF,
    parameter int NW = nsel_width(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef SCHED_ABORT_EN
    input  logic          abort,
`endif
    input  logic [OW-1:0] dp_out,
    output logic          dp_clr,
    output logic          dp_ld,
    output logic [IW-1:0] idx,
    output logic [NW-1:0] nsel,
    output logic          res_we,
    output logic [NW-1:0] res_addr,
    output logic [OW-1:0] res_data,
    output logic          busy,
    output logic          ready,
    output logic          done
);

    if (N < 1 || longint'(N) > (longint'(1) << IW)) begin : g_bad_n
        $error("neuron_layer_sched: N must be in 1..2**IW");
    end
    if (M < 1) begin : g_bad_m
        $error("neuron_layer_sched: M must be at least 1");
    end

    localparam logic [NW-1:0] NSEL_LAST = NW'(M - 1);

    state_t        state_q, state_d;
    logic [NW-1:0] nsel_q, nsel_d;
    logic          cnt_clr, cnt_inc, cnt_term;
    logic          abort_i;

`ifdef SCHED_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    step_counter #(.IW(IW), .N(N)) u_step (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (idx),
        .term  (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        nsel_d  = nsel_q;
        dp_clr  = 1'b0;
        dp_ld   = 1'b0;
        res_we  = 1'b0;
        done    = 1'b0;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort_i) begin
                    state_d = CLR;
                    nsel_d  = '0;
                end
            end
            CLR: begin
                dp_clr  = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                dp_ld   = 1'b1;
                cnt_inc = 1'b1;
                cnt_clr = cnt_term;
                if (cnt_term) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                res_we = 1'b1;
                if (nsel_q == NSEL_LAST) begin
                    state_d = DONE;
                end else begin
                    nsel_d  = nsel_q + NW'(1);
                    state_d = CLR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops the run outright: no capture or completion in that cycle.
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            nsel_d  = '0;
            res_we  = 1'b0;
            done    = 1'b0;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            nsel_q  <= '0;
        end else begin
            state_q <= state_d;
            nsel_q  <= nsel_d;
        end
    end

    assign nsel     = nsel_q;
    assign res_addr = nsel_q;
    assign res_data = res_we ? dp_out : '0;
    assign busy     = (state_q != IDLE);
    assign ready    = (state_q == IDLE);

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Self-checking bench for neuron_layer_sched: per-cycle reference model plus literal timing checks.
module tb_neuron_layer_sched;

    localparam int N      = 10;
    localparam int M      = 4;
    localparam int IW     = 16;
    localparam int OW     = 16;
    localparam int NW     = 2;
    localparam int P      = N + 2;
    localparam int LAST_T = M * P + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [OW-1:0] dp_out;
    logic          dp_clr, dp_ld, res_we, busy, ready, done;
    logic [IW-1:0] idx;
    logic [NW-1:0] nsel, res_addr;
    logic [OW-1:0] res_data;

    neuron_layer_sched #(.N(N), .M(M), .IW(IW), .OW(OW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SCHED_ABORT_EN
        .abort    (abort),
`endif
        .dp_out   (dp_out),
        .dp_clr   (dp_clr),
        .dp_ld    (dp_ld),
        .idx      (idx),
        .nsel     (nsel),
        .res_we   (res_we),
        .res_addr (res_addr),
        .res_data (res_data),
        .busy     (busy),
        .ready    (ready),
        .done     (done)
    );

    // Second instance for the N=1, M=1 edge configuration.
    logic          start1 = 1'b0;
    logic          abort1 = 1'b0;
    logic [OW-1:0] dp_out1 = 16'h00ab;
    logic          dp_clr1, dp_ld1, res_we1, busy1, ready1, done1;
    logic [IW-1:0] idx1;
    logic [0:0]    nsel1, res_addr1;
    logic [OW-1:0] res_data1;

    neuron_layer_sched #(.N(1), .M(1), .IW(IW), .OW(OW)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
`ifdef SCHED_ABORT_EN
        .abort    (abort1),
`endif
        .dp_out   (dp_out1),
        .dp_clr   (dp_clr1),
        .dp_ld    (dp_ld1),
        .idx      (idx1),
        .nsel     (nsel1),
        .res_we   (res_we1),
        .res_addr (res_addr1),
        .res_data (res_data1),
        .busy     (busy1),
        .ready    (ready1),
        .done     (done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: product table indexed by the scheduler's nsel/idx.
    logic [11:0]   tbl [M][N];
    logic [OW-1:0] acc = '0;
    assign dp_out = acc;

    function automatic int prod(input logic [NW-1:0] ns, input logic [IW-1:0] ix);
        if (int'(ix) < N) return int'(tbl[ns][ix]);
        return 0;
    endfunction

    function automatic int sum_of(input int k);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(tbl[k][i]);
        return s & 32'hffff;
    endfunction

    always @(posedge clk) begin
        if (dp_clr) acc <= '0;
        else if (dp_ld) acc <= acc + OW'(prod(nsel, idx));
    end

    // Reference model: t = position within the current run, 0 when idle.
    int            cyc  = 0;
    int            base = 0;
    int            t    = 0;
    logic [NW-1:0] idle_nsel = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            t = 0;
            idle_nsel = '0;
        end else if (t == 0) begin
            if (start && !abort) t = 1;
        end else if (abort) begin
            t = 0;
            idle_nsel = '0;
        end else if (t == LAST_T) begin
            t = 0;
            idle_nsel = NW'(M - 1);
        end else begin
            t = t + 1;
        end
    end

    int   we_cyc[$];
    int   we_addr[$];
    logic [OW-1:0] we_data[$];
    logic [OW-1:0] exp_q[$];
    int   done_cyc[$];
    int   ld_idx[$];
    int   clr_cnt  = 0;
    int   busy_cnt = 0;

    always @(negedge clk) begin
        int k, r;
        logic e_clr, e_ld, e_we, e_done;
        logic [NW-1:0] e_nsel;
        k = (t > 0) ? (t - 1) / P : 0;
        r = (t > 0) ? (t - 1) % P : 0;
        e_clr  = (t > 0 && t < LAST_T && r == 0);
        e_ld   = (t > 0 && t < LAST_T && r >= 1 && r <= N);
        e_we   = (t > 0 && t < LAST_T && r == N + 1) && !abort;
        e_done = (t == LAST_T) && !abort;
        if (t == 0) e_nsel = idle_nsel;
        else if (t == LAST_T) e_nsel = NW'(M - 1);
        else e_nsel = NW'(k);
        chk("m_busy", busy, t != 0);
        chk("m_ready", ready, t == 0);
        chk("m_dp_clr", dp_clr, e_clr);
        chk("m_dp_ld", dp_ld, e_ld);
        chk("m_res_we", res_we, e_we);
        chk("m_done", done, e_done);
        chk("m_nsel", nsel, e_nsel);
        chk("m_res_addr", res_addr, e_nsel);
        chk("m_res_data", res_data, e_we ? sum_of(k) : 0);
        if (e_clr || e_ld) chk("m_idx", idx, e_ld ? r - 1 : 0);
        if (res_we) begin
            we_cyc.push_back(cyc - base + 1);
            we_addr.push_back(int'(res_addr));
            we_data.push_back(res_data);
        end
        if (done) done_cyc.push_back(cyc - base + 1);
        if (dp_ld) ld_idx.push_back(int'(idx));
        if (dp_clr) clr_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        we_cyc.delete();
        we_addr.delete();
        we_data.delete();
        done_cyc.delete();
        ld_idx.delete();
        clr_cnt  = 0;
        busy_cnt = 0;
    endtask

    // Start is sampled at the following edge, which is "edge 0"; returns in cycle len.
    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        base  = cyc + 1;
        repeat (len) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic goto_cycle(input int c);
        int n = 0;
        while ((cyc - base + 1) < c && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_idle(input int budget, output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < budget);
        c = cyc - base + 1;
        chk("wait_idle_bound", ready, 1'b1);
    endtask

    task automatic rand_tbl();
        for (int k = 0; k < M; k++)
            for (int i = 0; i < N; i++)
                tbl[k][i] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, kind, dc;
        for (int k = 0; k < M; k++)
            for (int i = 0; i < N; i++)
                tbl[k][i] = 12'(k + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_idx", idx, 0);
        chk("rst_nsel", nsel, 0);
        chk("rst_res_we", res_we, 1'b0);
        chk("rst_res_data", res_data, 0);
        chk("rst_dp_clr", dp_clr, 1'b0);
        chk("rst_dp_ld", dp_ld, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single run with product = nsel+1.
        clear_logs();
        exp_q = '{16'd10, 16'd20, 16'd30, 16'd40};
        pulse_start(1);
        wait_idle(200, c);
        chk("t1_ready_cycle", c, 50);
        chk("t1_we_count", we_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_we_cycle", (i < we_cyc.size()) ? we_cyc[i] : -1, 12 * (i + 1));
            chk("t1_we_addr", (i < we_addr.size()) ? we_addr[i] : -1, i);
            chk("t2_res_data", (i < we_data.size()) ? we_data[i] : 16'hffff, exp_q[i]);
        end
        chk("t1_done_count", done_cyc.size(), 1);
        chk("t1_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 49);
        chk("t1_busy_cycles", busy_cnt, 49);
        chk("t2_clr_count", clr_cnt, 4);
        chk("t2_ld_count", ld_idx.size(), 40);
        for (int i = 0; i < 40; i++)
            chk("t2_idx_walk", (i < ld_idx.size()) ? ld_idx[i] : -1, i % N);

        // start held high: back-to-back runs with one idle cycle between.
        rand_tbl();
        clear_logs();
        pulse_start(120);
        wait_idle(200, c);
        chk("t3_done_count", done_cyc.size(), 3);
        chk("t3_done_0", (done_cyc.size() > 0) ? done_cyc[0] : -1, 49);
        chk("t3_done_1", (done_cyc.size() > 1) ? done_cyc[1] : -1, 99);
        chk("t3_done_2", (done_cyc.size() > 2) ? done_cyc[2] : -1, 149);
        chk("t3_we_count", we_cyc.size(), 12);

        // Reset in cycle 20 (neuron 1 accumulating).
        clear_logs();
        pulse_start(1);
        goto_cycle(20);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ready", ready, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_idx", idx, 0);
        chk("t4_nsel", nsel, 0);
        chk("t4_dp_ld", dp_ld, 1'b0);
        chk("t4_res_data", res_data, 0);
        repeat (80) @(negedge clk);
        chk("t4_we_count", we_cyc.size(), 1);
        chk("t4_done_count", done_cyc.size(), 0);

        // N=1, M=1 instance.
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        chk("t5_c1_clr", dp_clr1, 1'b1);
        chk("t5_c1_busy", busy1, 1'b1);
        chk("t5_c1_ld", dp_ld1, 1'b0);
        @(negedge clk);
        chk("t5_c2_ld", dp_ld1, 1'b1);
        chk("t5_c2_idx", idx1, 0);
        chk("t5_c2_clr", dp_clr1, 1'b0);
        @(negedge clk);
        chk("t5_c3_we", res_we1, 1'b1);
        chk("t5_c3_data", res_data1, 16'h00ab);
        chk("t5_c3_addr", res_addr1, 0);
        chk("t5_c3_ld", dp_ld1, 1'b0);
        @(negedge clk);
        chk("t5_c4_done", done1, 1'b1);
        chk("t5_c4_we", res_we1, 1'b0);
        @(negedge clk);
        chk("t5_c5_ready", ready1, 1'b1);
        chk("t5_c5_done", done1, 1'b0);

`ifdef SCHED_ABORT_EN
        // Abort during CAPT of neuron 1, then abort+start together in IDLE.
        clear_logs();
        pulse_start(1);
        goto_cycle(24);
        abort = 1'b1;
        @(negedge clk);
        chk("t6_no_we", res_we, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_idle_25", ready, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("t6_abort_wins", ready, 1'b1);
        repeat (60) @(negedge clk);
        chk("t6_we_count", we_cyc.size(), 1);
        chk("t6_done_count", done_cyc.size(), 0);
`endif

        // Randomized runs with occasional reset/abort disruption.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            rand_tbl();
            clear_logs();
            kind = $urandom_range(0, 3);
            dc   = $urandom_range(4, 48);
            pulse_start($urandom_range(1, 3));
            if (kind == 0) begin
                goto_cycle(dc);
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
            end
`ifdef SCHED_ABORT_EN
            else if (kind == 1) begin
                goto_cycle(dc);
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
`endif
            wait_idle(200, c);
            if (kind >= 2) begin
                chk("rnd_we_count", we_cyc.size(), 4);
                chk("rnd_done_count", done_cyc.size(), 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
